// File: rtl/ext_mem_router.sv
// rtl/ext_mem_router.sv - CPU memory port router to NUM_REGIONS base/mask decoded slave regions
//
// Purpose:
//   Decodes one CPU word address against programmable base/mask windows.
//   Each access is registered and runs through IDLE -> ACCESS -> RESP.
//   A miss skips ACCESS and reports err_o in RESP.
//   A slave that holds its wait for TIMEOUT cycles is abandoned with err_o.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   addr_i / wdata_i    CPU word address and write data
//   be_i                CPU byte enables
//   re_i / we_i         CPU read/write request levels (write wins if both high)
//   rdata_o             read result, valid in RESP
//   needWait_o          CPU must hold its request while high
//   err_o               unmapped or timed-out access, RESP cycle only
//   addr_o              region-local offset of the latched address
//   wdata_o / be_o      latched write data and byte enables (all ones on reads)
//   re_o / we_o         one-hot per-region strobes during ACCESS
//   rdata_i             per-region read data, region i at [i*DATA_W +: DATA_W]
//   needWait_i          per-region wait
module ext_mem_router #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {24'h800000, 24'h480000, 24'h400000, 24'h000000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
    {24'h800000, 24'hFFFFFE, 24'hF80000, 24'hC00000},
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic [DATA_W/8-1:0]           be_i,
  input  logic                          re_i,
  input  logic                          we_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          needWait_o,
  output logic                          err_o,
  output logic [ADDR_W-1:0]             addr_o,
  output logic [DATA_W-1:0]             wdata_o,
  output logic [DATA_W/8-1:0]           be_o,
  output logic [NUM_REGIONS-1:0]        re_o,
  output logic [NUM_REGIONS-1:0]        we_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] rdata_i,
  input  logic [NUM_REGIONS-1:0]        needWait_i
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              rw_q;     // 1 = write
  logic [SW-1:0]     sel_q;
  logic [TW-1:0]     timer_q;

  logic              req;
  logic              hit_any;
  logic [SW-1:0]     hit_idx;
  logic [ADDR_W-1:0] local_addr;
  logic              sel_wait;
  logic [DATA_W-1:0] sel_rdata;
  logic              timer_done;

  assign req        = re_i | we_i;
  assign timer_done = (timer_q == TIMER_LAST);

  // Address decode: scanning from the top down lets the lowest matching
  // index overwrite higher ones, so the lowest region wins on overlap.
  always_comb begin
    hit_any    = 1'b0;
    hit_idx    = '0;
    local_addr = addr_i;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_any    = 1'b1;
        hit_idx    = SW'(i);
        local_addr = addr_i & ~REGION_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Selected slave's wait and read data.
  always_comb begin
    sel_wait  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q == SW'(i)) begin
        sel_wait  = needWait_i[i];
        sel_rdata = rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = hit_any ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        if (!sel_wait || timer_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. Strobes are decoded from the state, so an asynchronous reset
  // drops them in the same cycle it arrives.
  always_comb begin
    re_o       = '0;
    we_o       = '0;
    needWait_o = req & (state_q != ST_RESP);
    if (state_q == ST_ACCESS) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (sel_q == SW'(i)) begin
          re_o[i] = ~rw_q;
          we_o[i] = rw_q;
        end
      end
    end
  end

  // Access datapath: latch on request, capture or fault on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      sel_q   <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= local_addr;
            wdata_q <= wdata_i;
            be_q    <= we_i ? be_i : {BE_W{1'b1}};
            rw_q    <= we_i;
            sel_q   <= hit_idx;
            timer_q <= '0;
            if (!hit_any) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (!sel_wait) begin
            err_q <= 1'b0;
            // Writes leave the previous read result on rdata_o.
            if (!rw_q) begin
              rdata_q <= sel_rdata;
            end
          end else if (timer_done) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESP: begin
          err_q <= 1'b0;
        end
        default: begin
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign be_o    = be_q;

endmodule

// File: tb/tb_ext_mem_router.sv
// tb/tb_ext_mem_router.sv - randomized self-checking bench for ext_mem_router
module tb_ext_mem_router;

  localparam int NR = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   addr_i;
  logic [DW-1:0]   wdata_i;
  logic [BW-1:0]   be_i;
  logic            re_i;
  logic            we_i;
  logic [DW-1:0]   rdata_o;
  logic            needWait_o;
  logic            err_o;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   wdata_o;
  logic [BW-1:0]   be_o;
  logic [NR-1:0]   re_o;
  logic [NR-1:0]   we_o;
  logic [NR*DW-1:0] rdata_i;
  logic [NR-1:0]   needWait_i;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rdata_exp;

  ext_mem_router #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .be_i       (be_i),
    .re_i       (re_i),
    .we_i       (we_i),
    .rdata_o    (rdata_o),
    .needWait_o (needWait_o),
    .err_o      (err_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .be_o       (be_o),
    .re_o       (re_o),
    .we_o       (we_o),
    .rdata_i    (rdata_i),
    .needWait_i (needWait_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory map as plain address ranges: flash, SRAM, LED, DRAM; -1 = unmapped.
  function automatic int region_of(input logic [AW-1:0] a);
    if (a < 24'h400000) return 0;
    if (a < 24'h480000) return 1;
    if (a <= 24'h480001) return 2;
    if (a >= 24'h800000) return 3;
    return -1;
  endfunction

  function automatic logic [AW-1:0] region_start(input int r);
    case (r)
      1:       return 24'h400000;
      2:       return 24'h480000;
      3:       return 24'h800000;
      default: return 24'h000000;
    endcase
  endfunction

  // Entered at a negedge in IDLE (or in RESP when from_resp, request held).
  // The slave waits `waits` ACCESS cycles; waits >= TO means stuck.
  // Returns at the negedge of the RESP cycle.
  task automatic do_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [BW-1:0] be, input int waits, input bit from_resp);
    int r;
    int n;
    bit exp_err;
    logic [NR-1:0] strobe;
    r = region_of(a);
    for (int i = 0; i < NR; i++) rdata_i[i*DW +: DW] = DW'($urandom);
    addr_i     = a;
    wdata_i    = wd;
    be_i       = be;
    re_i       = !wr;
    we_i       = wr;
    needWait_i = '1;
    if (from_resp) begin
      #1;
      chk("resp_hold_nw", {31'd0, needWait_o}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("idle_nw", {31'd0, needWait_o}, 32'd1);
    chk("idle_strobe", {24'd0, re_o, we_o}, 32'd0);
    if (r < 0) begin
      n = 0; exp_err = 1'b1;
    end else if (waits < TO) begin
      n = waits + 1; exp_err = 1'b0;
    end else begin
      n = TO; exp_err = 1'b1;
    end
    strobe = (r >= 0) ? NR'(1 << r) : '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("acc_re", {28'd0, re_o}, {28'd0, wr ? 4'd0 : strobe});
      chk("acc_we", {28'd0, we_o}, {28'd0, wr ? strobe : 4'd0});
      chk("acc_nw", {31'd0, needWait_o}, 32'd1);
      if (k == 0) begin
        chk("addr_o", {8'd0, addr_o}, {8'd0, a - region_start(r)});
        chk("be_o", {30'd0, be_o}, {30'd0, wr ? be : 2'b11});
        if (wr) chk("wdata_o", {16'd0, wdata_o}, {16'd0, wd});
      end
      needWait_i[r] = (k < waits);
    end
    @(negedge clk);
    if (exp_err) rdata_exp = '0;
    else if (!wr) rdata_exp = rdata_i[r*DW +: DW];
    chk("resp_nw", {31'd0, needWait_o}, 32'd0);
    chk("resp_err", {31'd0, err_o}, {31'd0, exp_err});
    chk("resp_rdata", {16'd0, rdata_o}, {16'd0, rdata_exp});
    chk("resp_strobe", {24'd0, re_o, we_o}, 32'd0);
    needWait_i = '1;
  endtask

  // From the RESP negedge, drop the request and step into IDLE.
  task automatic idle();
    re_i = 1'b0;
    we_i = 1'b0;
    @(negedge clk);
    chk("idle_err", {31'd0, err_o}, 32'd0);
    chk("idle_rdata", {16'd0, rdata_o}, {16'd0, rdata_exp});
    chk("idle_quiet", {23'd0, needWait_o, re_o, we_o}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_re"}, {28'd0, re_o}, 32'd0);
    chk({tag, "_we"}, {28'd0, we_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, rdata_o}, 32'd0);
    chk({tag, "_addr"}, {8'd0, addr_o}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, wdata_o}, 32'd0);
    chk({tag, "_be"}, {30'd0, be_o}, 32'd0);
  endtask

  initial begin
    bit hold;
    int cls;
    bit wr;
    logic [AW-1:0] a;
    rst_n      = 1'b0;
    addr_i     = '0;
    wdata_i    = '0;
    be_i       = '0;
    re_i       = 1'b0;
    we_i       = 1'b0;
    rdata_i    = '0;
    needWait_i = '1;
    rdata_exp  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_nw", {31'd0, needWait_o}, 32'd0);

    // Flash read, no wait
    do_access(1'b0, 24'h000010, 16'h0, 2'b11, 0, 1'b0);
    idle();
    // SRAM write, 3 wait cycles
    do_access(1'b1, 24'h400123, 16'hBEEF, 2'b10, 3, 1'b0);
    idle();
    // Unmapped read
    do_access(1'b0, 24'h600000, 16'h0, 2'b11, 0, 1'b0);
    idle();
    // DRAM read with slave stuck
    do_access(1'b0, 24'h800004, 16'h0, 2'b11, 1000, 1'b0);
    idle();

    // Reset during the 2nd ACCESS cycle of an LED write
    addr_i  = 24'h480001;
    wdata_i = 16'h1234;
    be_i    = 2'b01;
    we_i    = 1'b1;
    re_i    = 1'b0;
    needWait_i = '1;
    @(negedge clk);
    chk("led_we1", {28'd0, we_o}, 32'h4);
    @(negedge clk);
    chk("led_we2", {28'd0, we_o}, 32'h4);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    rdata_exp = '0;
    we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_quiet", {23'd0, needWait_o, re_o, we_o}, 32'd0);

    // Back-to-back reads held across RESP
    do_access(1'b0, 24'h480000, 16'h0, 2'b11, 0, 1'b0);
    do_access(1'b0, 24'h800000, 16'h0, 2'b11, 2, 1'b1);
    idle();

    // Randomized accesses
    hold = 1'b0;
    for (int t = 0; t < 60; t++) begin
      cls = $urandom_range(0, 4);
      case (cls)
        0:       a = AW'($urandom_range(0, 24'h3FFFFF));
        1:       a = 24'h400000 + AW'($urandom_range(0, 24'h7FFFF));
        2:       a = 24'h480000 + AW'($urandom_range(0, 1));
        3:       a = 24'h800000 + AW'($urandom_range(0, 24'h7FFFFF));
        default: a = AW'($urandom);
      endcase
      wr = 1'($urandom_range(0, 1));
      do_access(wr, a, DW'($urandom), BW'($urandom), $urandom_range(0, 10), hold);
      hold = 1'($urandom_range(0, 1));
      if (!hold) idle();
    end
    if (hold) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
